vproc_sim_timer: RTL and testbench

- Memory-mapped countdown timer on the VProc bus, alongside the simulation-control block, in Verilator test harnesses.
- Drives the VProc interrupt input, which the simulation-control block currently ties to 0, so test software can take timed interrupts instead of polling the cycle count.
- Programmable reload value and prescaler; one-shot or periodic operation; sticky, write-1-to-clear pending flag.

---
 rtl/vproc_sim_timer_pkg.sv | 36 +++
 rtl/vproc_sim_timer_prescaler.sv | 33 +++
 rtl/vproc_sim_timer.sv | 181 ++++++++++++++++++
 tb/tb_vproc_sim_timer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_sim_timer_pkg.sv
// Shared definitions for the VProc countdown timer: register offsets, CTRL bit
// positions, CTRL register struct and the run/idle state encoding.
package vproc_sim_timer_pkg;

    localparam logic [31:0] TMR_CTRL_OFF     = 32'h0000_0000;
    localparam logic [31:0] TMR_LOAD_OFF     = 32'h0000_0004;
    localparam logic [31:0] TMR_COUNT_OFF    = 32'h0000_0008;
    localparam logic [31:0] TMR_STATUS_OFF   = 32'h0000_000C;
    localparam logic [31:0] TMR_PRESCALE_OFF = 32'h0000_0010;
    localparam logic [31:0] TMR_EXPIRIES_OFF = 32'h0000_0014;

    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_PERIODIC_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT   = 2;

    // EN lives in the state register; the struct holds the remaining CTRL bits
    typedef struct packed {
        logic irq_en;
        logic periodic;
    } tmr_ctrl_t;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_t;

    function automatic logic [31:0] ctrl_rd_word(input logic en, input tmr_ctrl_t c);
        logic [31:0] w;
        w                    = '0;
        w[CTRL_EN_BIT]       = en;
        w[CTRL_PERIODIC_BIT] = c.periodic;
        w[CTRL_IRQ_EN_BIT]   = c.irq_en;
        return w;
    endfunction

endpackage

// File: rtl/vproc_sim_timer_prescaler.sv
// 16-bit prescale counter: counts while enabled, wraps at the PRESCALE value and
// emits a single-cycle tick on the wrap. A clear suppresses that cycle's tick.
module vproc_sim_timer_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        tick  = en && !clr && (cnt_q == prescale);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vproc_sim_timer.sv
// Memory-mapped countdown timer with prescaler, one-shot/periodic modes and a
// sticky W1C pending flag driving irq. Define VSC_TIMER_EXPIRY_COUNT_EN for EXPIRIES.
module vproc_sim_timer
    import vproc_sim_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'hB000_0100,
    parameter logic [15:0] RESET_PRESCALE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] rdata,
    output logic        irq
);

    tmr_state_t  state_q, state_d;
    tmr_ctrl_t   ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic [31:0] off;
    logic        wr_ctrl, wr_load, wr_count, wr_status, wr_prescale;
    logic        presc_clr;
    logic        tick;
    logic        expire;
    logic [31:0] expiries_rd;

    always_comb begin
        off         = addr - BASE_ADDR;
        wr_ctrl     = we && (off == TMR_CTRL_OFF);
        wr_load     = we && (off == TMR_LOAD_OFF);
        wr_count    = we && (off == TMR_COUNT_OFF);
        wr_status   = we && (off == TMR_STATUS_OFF);
        wr_prescale = we && (off == TMR_PRESCALE_OFF);
    end

    vproc_sim_timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == TMR_RUN),
        .clr      (presc_clr),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // Tick effects are computed first; bus writes then override them, which
    // gives write-wins for COUNT and set-wins for PEND.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        count_d    = count_q;
        pend_d     = pend_q;
        prescale_d = prescale_q;
        presc_clr  = 1'b0;
        expire     = 1'b0;

        if (tick) begin
            if (count_q == '0) begin
                expire = 1'b1;
                if (ctrl_q.periodic) begin
                    count_d = load_q;
                end else begin
                    state_d = TMR_IDLE;
                end
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        if (wr_ctrl) begin
            ctrl_d.periodic = wdata[CTRL_PERIODIC_BIT];
            ctrl_d.irq_en   = wdata[CTRL_IRQ_EN_BIT];
            if (wdata[CTRL_EN_BIT]) begin
                state_d = TMR_RUN;
                if (state_q == TMR_IDLE) begin
                    count_d   = load_q;
                    presc_clr = 1'b1;
                end
            end else begin
                state_d = TMR_IDLE;
            end
        end
        if (wr_load) begin
            load_d = wdata;
        end
        if (wr_count) begin
            count_d   = wdata;
            presc_clr = 1'b1;
        end
        if (wr_prescale) begin
            prescale_d = wdata[15:0];
        end
        if (wr_status && wdata[0]) begin
            pend_d = 1'b0;
        end
        if (expire) begin
            pend_d = 1'b1;
        end

        irq_d = pend_d & ctrl_d.irq_en;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            case (off)
                TMR_CTRL_OFF:     rdata_d = ctrl_rd_word(state_q == TMR_RUN, ctrl_q);
                TMR_LOAD_OFF:     rdata_d = load_q;
                TMR_COUNT_OFF:    rdata_d = count_q;
                TMR_STATUS_OFF:   rdata_d = {31'b0, pend_q};
                TMR_PRESCALE_OFF: rdata_d = {16'b0, prescale_q};
                TMR_EXPIRIES_OFF: rdata_d = expiries_rd;
                default:          rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TMR_IDLE;
            ctrl_q     <= '0;
            load_q     <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            prescale_q <= RESET_PRESCALE;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            prescale_q <= prescale_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

`ifdef VSC_TIMER_EXPIRY_COUNT_EN
    logic [31:0] expiries_q, expiries_d;

    // A clearing write and an expiry in the same cycle leave the counter at 1
    always_comb begin
        expiries_d = expiries_q;
        if (we && (off == TMR_EXPIRIES_OFF)) begin
            expiries_d = '0;
        end
        if (expire) begin
            expiries_d = expiries_d + 32'd1;
        end
        expiries_rd = expiries_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            expiries_q <= '0;
        end else begin
            expiries_q <= expiries_d;
        end
    end
`else
    always_comb begin
        expiries_rd = '0;
    end
`endif

    always_comb begin
        rdata = rdata_q;
        irq   = irq_q;
    end

endmodule

// File: tb/tb_vproc_sim_timer.sv
// Self-checking bench for vproc_sim_timer: register table, directed timing
// sequences and randomized bus traffic against a cycle-level reference model.
module tb_vproc_sim_timer;

    localparam logic [31:0] BASE = 32'hB000_0100;
    localparam logic [15:0] RP   = 16'h0007;

    localparam logic [31:0] O_CTRL  = 32'h00;
    localparam logic [31:0] O_LOAD  = 32'h04;
    localparam logic [31:0] O_COUNT = 32'h08;
    localparam logic [31:0] O_STAT  = 32'h0C;
    localparam logic [31:0] O_PRESC = 32'h10;
    localparam logic [31:0] O_EXP   = 32'h14;
    localparam logic [31:0] O_UNMAP = 32'h40;

`ifdef VSC_TIMER_EXPIRY_COUNT_EN
    localparam bit HAS_EXP = 1'b1;
`else
    localparam bit HAS_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] rdata;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    vproc_sim_timer #(
        .BASE_ADDR      (BASE),
        .RESET_PRESCALE (RP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rd    (rd),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Reference model: timer state as plain integers, advanced once per clock.
    bit          m_en, m_per, m_ien, m_pend, m_irq;
    int unsigned m_load, m_count, m_phase, m_presc, m_exp;
    logic [31:0] m_rdata;

    function automatic logic [31:0] model_read(input logic [31:0] o);
        case (o)
            O_CTRL:  return {29'b0, m_ien, m_per, m_en};
            O_LOAD:  return m_load;
            O_COUNT: return m_count;
            O_STAT:  return {31'b0, m_pend};
            O_PRESC: return m_presc;
            O_EXP:   return HAS_EXP ? m_exp : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit w, input bit rv,
                              input logic [31:0] o, input logic [31:0] wd);
        bit was_en;
        bit tick;
        bit expire;
        if (r) begin
            m_en = 0; m_per = 0; m_ien = 0; m_pend = 0; m_irq = 0;
            m_load = 0; m_count = 0; m_phase = 0; m_presc = RP; m_exp = 0;
            m_rdata = '0;
            return;
        end
        was_en = m_en;
        tick   = 0;
        expire = 0;
        if (rv) m_rdata = model_read(o);
        if (m_en && !(w && o == O_COUNT)) begin
            if (m_phase == m_presc) begin
                tick    = 1;
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
            end
        end
        if (tick) begin
            if (m_count == 0) expire = 1;
            else m_count = m_count - 1;
        end
        if (expire) begin
            m_pend = 1;
            m_exp  = m_exp + 1;
            if (m_per) m_count = m_load;
            else m_en = 0;
        end
        if (w) begin
            case (o)
                O_CTRL: begin
                    m_per = wd[1];
                    m_ien = wd[2];
                    if (wd[0] && !was_en) begin
                        m_count = m_load;
                        m_phase = 0;
                    end
                    m_en = wd[0];
                end
                O_LOAD:  m_load = wd;
                O_COUNT: begin
                    m_count = wd;
                    m_phase = 0;
                end
                O_STAT:  if (wd[0] && !expire) m_pend = 0;
                O_PRESC: m_presc = wd[15:0];
                O_EXP:   m_exp = expire ? 1 : 0;
                default: ;
            endcase
        end
        m_irq = m_pend & m_ien;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One bus cycle: drive, clock, advance the model, then compare outputs.
    task automatic cycle(input bit r, input bit w, input bit rv,
                         input logic [31:0] o, input logic [31:0] wd);
        rst   = r;
        we    = w;
        rd    = rv;
        addr  = BASE + o;
        wdata = wd;
        @(posedge clk);
        model_step(r, w, rv, o, wd);
        #1;
        check("irq_vs_model", {31'b0, irq}, {31'b0, m_irq});
        check("rdata_vs_model", rdata, m_rdata);
        rst = 1'b0;
        we  = 1'b0;
        rd  = 1'b0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, O_CTRL, 32'd0);
    endtask

    typedef struct {
        bit          w;
        bit          r;
        logic [31:0] o;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] rd_offs[8] = '{O_CTRL, O_LOAD, O_COUNT, O_STAT, O_PRESC, O_EXP, O_UNMAP, 32'h18};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        cycle(1, 0, 0, O_CTRL, 0);
        cycle(1, 0, 0, O_CTRL, 0);
        check("reset_irq", {31'b0, irq}, 32'd0);
        check("reset_rdata", rdata, 32'd0);

        vecs = '{
            '{0, 1, O_CTRL,  0, 0},
            '{0, 1, O_LOAD,  0, 0},
            '{0, 1, O_COUNT, 0, 0},
            '{0, 1, O_STAT,  0, 0},
            '{0, 1, O_PRESC, 0, 32'(RP)},
            '{0, 1, O_EXP,   0, 0},
            '{1, 0, O_LOAD,  32'hDEAD_BEEF, 0},
            '{0, 1, O_LOAD,  0, 32'hDEAD_BEEF},
            '{1, 0, O_PRESC, 32'h1234_5678, 0},
            '{0, 1, O_PRESC, 0, 32'h0000_5678},
            '{1, 0, O_CTRL,  32'hFFFF_FFF8, 0},
            '{0, 1, O_CTRL,  0, 0},
            '{1, 0, O_CTRL,  32'h0000_0006, 0},
            '{0, 1, O_CTRL,  0, 32'h0000_0006},
            '{1, 0, O_UNMAP, 32'h0000_0055, 0},
            '{0, 1, O_UNMAP, 0, 0},
            '{0, 1, O_LOAD,  0, 32'hDEAD_BEEF},
            '{1, 0, O_CTRL,  32'h0, 0},
            '{0, 1, O_STAT,  0, 0}
        };
        foreach (vecs[i]) begin
            cycle(0, vecs[i].w, vecs[i].r, vecs[i].o, vecs[i].wd);
            if (vecs[i].r) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
        end

        // One-shot: LOAD=4, PRESCALE=0 expires on the 5th edge after enabling.
        cycle(0, 1, 0, O_LOAD, 32'd4);
        cycle(0, 1, 0, O_PRESC, 32'd0);
        cycle(0, 1, 0, O_CTRL, 32'h5);
        for (int unsigned i = 1; i <= 5; i++) begin
            idle();
            check($sformatf("oneshot_irq_c%0d", i), {31'b0, irq}, 32'(i == 5));
        end
        cycle(0, 0, 1, O_CTRL, 0);
        check("oneshot_ctrl_en_clear", rdata, 32'h4);
        cycle(0, 0, 1, O_COUNT, 0);
        check("oneshot_count", rdata, 32'd0);
        cycle(0, 0, 1, O_STAT, 0);
        check("oneshot_pend", rdata, 32'd1);
        for (int unsigned i = 0; i < 4; i++) idle();
        cycle(0, 0, 1, O_COUNT, 0);
        check("oneshot_count_hold", rdata, 32'd0);

        // Periodic: LOAD=2, PRESCALE=3 gives 12-cycle period; W1C at 14 and on the 36 expiry.
        cycle(0, 1, 0, O_STAT, 32'd1);
        cycle(0, 1, 0, O_EXP, 32'd0);
        cycle(0, 1, 0, O_LOAD, 32'd2);
        cycle(0, 1, 0, O_PRESC, 32'd3);
        cycle(0, 1, 0, O_CTRL, 32'h7);
        for (int unsigned i = 1; i <= 36; i++) begin
            if (i == 14 || i == 36) cycle(0, 1, 0, O_STAT, 32'd1);
            else idle();
            check($sformatf("periodic_irq_c%0d", i), {31'b0, irq},
                  32'((i >= 12 && i < 14) || i >= 24));
        end
        cycle(0, 0, 1, O_EXP, 0);
        check("periodic_expiries", rdata, HAS_EXP ? 32'd3 : 32'd0);
        cycle(0, 0, 1, O_STAT, 0);
        check("w1c_on_expiry_pend", rdata, 32'd1);

        // COUNT write mid-run, freeze, then re-enable reloads from LOAD.
        cycle(0, 1, 0, O_LOAD, 32'd50);
        cycle(0, 1, 0, O_COUNT, 32'd10);
        cycle(0, 1, 0, O_CTRL, 32'h0);
        cycle(0, 0, 1, O_COUNT, 0);
        check("freeze_count", rdata, 32'd10);
        for (int unsigned i = 0; i < 3; i++) idle();
        cycle(0, 0, 1, O_COUNT, 0);
        check("freeze_count_hold", rdata, 32'd10);
        cycle(0, 1, 0, O_CTRL, 32'h1);
        cycle(0, 0, 1, O_COUNT, 0);
        check("reenable_reload", rdata, 32'd50);

        // Re-writing EN=1 while running must not reload from the new LOAD.
        cycle(0, 1, 0, O_LOAD, 32'd100);
        cycle(0, 1, 0, O_CTRL, 32'h7);
        check("irq_unmask_pend", {31'b0, irq}, 32'd1);
        cycle(0, 0, 1, O_COUNT, 0);
        check("en_rewrite_no_reload", rdata, 32'd50);
        for (int unsigned i = 0; i < 5; i++) idle();
        cycle(1, 0, 0, O_CTRL, 0);
        check("midrun_reset_irq", {31'b0, irq}, 32'd0);
        check("midrun_reset_rdata", rdata, 32'd0);
        cycle(0, 0, 1, O_COUNT, 0);
        check("midrun_reset_count", rdata, 32'd0);
        cycle(0, 0, 1, O_STAT, 0);
        check("midrun_reset_pend", rdata, 32'd0);
        cycle(0, 0, 1, O_PRESC, 0);
        check("midrun_reset_presc", rdata, 32'(RP));

        // Randomized traffic against the model.
        for (int unsigned seg = 0; seg < 4; seg++) begin
            cycle(1, 0, 0, O_CTRL, 0);
            cycle(0, 1, 0, O_PRESC, 32'($urandom_range(0, 3)));
            for (int unsigned n = 0; n < 700; n++) begin
                int unsigned sel;
                sel = $urandom_range(0, 99);
                if (sel < 1)       cycle(1, 0, 0, O_CTRL, 0);
                else if (sel < 50) idle();
                else if (sel < 62) cycle(0, 0, 1, rd_offs[$urandom_range(0, 7)], 0);
                else if (sel < 72) cycle(0, 1, 0, O_CTRL,
                                         32'($urandom_range(0, 7)) | ($urandom & 32'hFFFF_FFF8));
                else if (sel < 79) cycle(0, 1, 0, O_LOAD, 32'($urandom_range(0, 6)));
                else if (sel < 85) cycle(0, 1, 0, O_COUNT, 32'($urandom_range(0, 6)));
                else if (sel < 93) cycle(0, 1, 0, O_STAT, $urandom);
                else if (sel < 97) cycle(0, 1, 0, O_EXP, $urandom);
                else               cycle(0, 1, 0, 32'h18, $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
